ram_sp_clr: RTL
===============

// Module: ram_sp_clr
// PURPOSE
//  Parametrised single-port synchronous RAM for lab datapaths: one read/write port, registered read data.
//  Built-in clear sequencer sweeps CLR_VAL into every word after reset or on request.
//  Read-during-write mode and an optional output register stage are selectable.
//  Sits between the user datapath (switch/key driven) and display logic; busy gates all user access.
// PARAMETERS
//  DATA_W   3              word width, bits
//  ADDR_W   5              address width; DEPTH = 2**ADDR_W words
//  RDW_MODE RDW_OLD        ram_pkg::rdw_mode_e; RDW_OLD returns prior word, RDW_NEW returns written data
//  OUT_REG  0              0: read latency 1; 1: extra output flop, read latency 2
//  CLR_VAL  '0             value written to every word by the clear sweep
// PORTS
//  clk      in   1       single clock, all logic on posedge
//  reset    in   1       synchronous, active-high; starts clear sweep
//  address  in   ADDR_W  word address for read and write
//  data     in   DATA_W  write data
//  wren     in   1       write enable
//  rden     in   1       read enable; q holds last value when no read issued
//  clear    in   1       1-cycle request to start clear sweep (level accepted)
//  busy     out  1       high while sweep in progress; user access ignored
//  q        out  DATA_W  read data
//  q_valid  out  1       1-cycle pulse aligned with new q
// BEHAVIOUR
//  Reset (sampled high on clk edge): state=CLEAR, cnt=0, busy=1, q=0, q_valid=0, output pipe flushed.
//  FSM states IDLE, CLEAR.
//   CLEAR: each cycle mem[cnt]<=CLR_VAL, cnt<=cnt+1; at cnt==DEPTH-1 write then go IDLE.
//   busy=1 for exactly DEPTH cycles after reset deasserts; busy=0 the cycle after last sweep write.
//   IDLE: clear==1 -> CLEAR with cnt=0, busy=1 next cycle; first sweep write happens in that CLEAR cycle.
//  clear while busy ignored (sweep not restarted); reset while busy restarts sweep at cnt=0.
//  reset has priority over clear, clear over user access in the same cycle.
//  While busy: wren, rden ignored; q holds; q_valid=0; in-flight OUT_REG read still completes.
//  User write (IDLE, wren=1): mem[address]<=data on the edge.
//  User read (IDLE, rden=1): q=mem[address] after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1);
//   q_valid high in the same cycle q updates; back-to-back reads give one result per cycle.
//  wren&rden same cycle (same address): RDW_OLD -> q=old word; RDW_NEW -> q=data.
//  cnt is ADDR_W+1 bits or compare-at-DEPTH-1; no wrap past DEPTH-1; address always in range (DEPTH=2**ADDR_W).
//  Memory contents undefined only before first sweep completes; never read before busy falls.
// STRUCTURE
//  ram_pkg: typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e; ram_state_e {IDLE, CLEAR}.
//  Sub-module ram_clr_seq: FSM + counter; outputs busy, clr_we, clr_addr. Top muxes sweep vs user port.
//  Memory array inferred as single-port block RAM; no reset on array itself.
// TESTING
//  1 reset 1 cycle, defaults -> busy high 32 cycles then low; read addr 0..31 -> q=0 each, q_valid pulses.
//  2 write addr 5 data 3'b101, next cycle rden addr 5 -> q=3'b101 one cycle later, q_valid=1 that cycle.
//  3 mem[7]=3'b010; wren+rden addr 7 data 3'b111 -> RDW_OLD q=3'b010; RDW_NEW q=3'b111.
//  4 fill mem, pulse clear, wren during busy -> busy 32 cycles, write dropped, all words read 0.
//  5 reset at cnt=10 mid-sweep -> cnt restarts 0, busy stays high 32 more cycles after reset falls.
//  6 OUT_REG=1, ADDR_W=4, DATA_W=8: reads on 3 consecutive cycles -> 3 q_valid pulses, latency 2, in order.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types for the clearable single-port RAM.
//   rdw_mode_e  : read-during-write behaviour (old word or new data)
//   ram_state_e : clear sequencer states
package ram_pkg;
  typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;
  typedef enum logic {IDLE, CLEAR}      ram_state_e;
endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: sweeps every address once after reset or on a clear
// request, then idles.
//   clk      : clock
//   reset    : sync active-high, (re)starts the sweep at address 0
//   clear    : sweep request, honoured only while idle
//   busy     : sweep in progress
//   clr_we   : write strobe for the sweep
//   clr_addr : address being cleared this cycle
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // DEPTH is a power of two, so the last word is cnt=='1; the counter
  // rolls back to 0 on that same edge, ready for the next sweep.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with built-in clear sweep.
//   clk, reset : clock, sync active-high reset (starts a sweep)
//   address    : word address for read and write
//   data, wren : write data / enable
//   rden       : read enable; q holds its value when no read completes
//   clear      : request a sweep of CLR_VAL into every word
//   busy       : sweep in progress, user access ignored
//   q, q_valid : read data and its one-cycle valid pulse
// Read latency is 1 cycle, or 2 with OUT_REG.
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int          DATA_W   = 3,
  parameter int          ADDR_W   = 5,
  parameter rdw_mode_e   RDW_MODE = RDW_OLD,
  parameter bit          OUT_REG  = 1'b0,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  input  logic              rden,
  input  logic              clear,
  output logic              busy,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int STAGES = OUT_REG ? 2 : 1;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_clr_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Reset beats clear beats user access; a sweep locks out the user.
  logic acc_en, wr_en, rd_en;
  assign acc_en = ~busy & ~clear & ~reset;
  assign wr_en  = acc_en & wren;
  assign rd_en  = acc_en & rden;

  // One shared port: the sweep owns it while busy.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  assign mem_we    = clr_we | wr_en;
  assign mem_addr  = clr_we ? clr_addr : address;
  assign mem_wdata = clr_we ? CLR_VAL  : data;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Stage 1 is the RAM read register; further stages are the optional
  // output flop. Valid and data only advance on a valid, so q holds.
  logic [STAGES:1]             vld_pipe;
  logic [STAGES:1][DATA_W-1:0] dat_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_en;
      if (rd_en)
        dat_pipe[1] <= (RDW_MODE == RDW_NEW && wren) ? data : mem[mem_addr];
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign q       = dat_pipe[STAGES];
  assign q_valid = vld_pipe[STAGES];

endmodule
